id_ex_register: RTL and testbench
=================================

# id_ex_register

Pipeline register between the ID and EX stages of the five-stage MIPS core. It captures the decoded control bits, the 2-bit ALU op class, the instruction funct field, operand values, the sign-extended immediate and register specifiers from ID. It presents them to EX on the next cycle, where `op`/`funct` drive ALU control. It supports hazard-unit stall (hold) and flush (bubble insertion), and keeps a saturating count of inserted bubbles for performance monitoring.

## Interface
- `CNT_W`, default 32: width of the bubble counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hold all EX-side outputs unchanged this cycle.
- `flush` input 1: load a bubble instead of the ID-side values.
- `valid_id` input 1: ID holds a real instruction.
- `reg_write_id`, `mem_to_reg_id`, `mem_read_id`, `mem_write_id`, `branch_id`, `alu_src_id`, `reg_dst_id` input 1 each: main-control bits.
- `alu_op_id` input 2: ALU op class (00 add, 01 sub, 10 R-type/funct, 11 and).
- `funct_id` input 6: instruction bits [5:0].
- `pc_plus4_id`, `rd1_id`, `rd2_id`, `imm_id` input 32 each: PC+4, register-file read data, sign-extended immediate.
- `rs_id`, `rt_id`, `rd_id` input 5 each: register specifiers.
- `*_ex` output (same widths): registered copies of every `*_id` input above, including `valid_ex`.
- `bubble_count` output `CNT_W`: number of bubbles inserted since reset; saturates.

## Operation
- Priority per rising edge: `reset` > `flush` > `stall` > normal load.
- Reset:
  - All `*_ex` outputs go to 0, including `valid_ex`.
  - `alu_op_ex` = 2'b00 and `funct_ex` = 6'b0, so EX computes a harmless add.
  - `bubble_count` = 0.
- Flush (`flush`=1, `reset`=0):
  - All `*_ex` outputs load 0; the data fields are also zeroed so the bubble's contents are deterministic.
  - `bubble_count` increments by 1 unless it is already all-ones.
  - `flush` overrides `stall` when both are 1.
- Stall (`stall`=1, `flush`=0, `reset`=0):
  - Every `*_ex` output and `bubble_count` hold their current values.
  - ID-side inputs are ignored.
- Normal load: every `*_ex` output takes the corresponding `*_id` value, bit-exact.
- `valid_id`=0 on a normal load:
  - Fields are still copied as presented.
  - `bubble_count` does not change; only flushes are counted.
- No combinational path from any input to any output.
- Counter saturation: at 2^`CNT_W`−1, further flushes leave the value unchanged; it never wraps.

## Timing
- Latency is 1 cycle: values present on `*_id` at edge N appear on `*_ex` immediately after edge N, when neither stall nor flush is active.
- A `reset` asserted mid-stream takes effect at the next edge and overrides any concurrent `stall` or `flush`.
- The first load can occur on the first edge with `reset`=0.
- Stall held for K cycles freezes the outputs for exactly K edges. The first edge with `stall`=0 loads whatever ID presents at that edge.
- Flush lasts one edge per asserted cycle. Holding `flush`=1 for K cycles produces K bubble cycles and adds K to the counter, subject to saturation.

## Test plan
- Reset: drive every `*_id` input to all-ones and hold `reset`=1 for 2 edges → all `*_ex` outputs = 0 and `bubble_count`=0. The cycle after `reset` falls, with inputs unchanged, the outputs are all-ones.
- Transfer: apply `alu_op_id`=2'b10, `funct_id`=6'b100010, `rd1_id`=32'h0000_0005, `rd2_id`=32'h0000_0003, `rd_id`=5'd9, `reg_write_id`=1 → exactly one edge later `*_ex` match those values. Back-to-back instructions on consecutive cycles each appear with 1-cycle latency.
- Stall: load `funct_id`=6'b100100, then assert `stall` for 3 cycles while changing every input → `*_ex` unchanged for all 3 cycles. On release, the value present at the release edge appears.
- Flush: load `reg_write_id`=1, `mem_write_id`=1, `alu_op_id`=2'b11, then `flush`=1 for 1 cycle → all `*_ex`=0 and `bubble_count`=1.
- Flush with stall: assert `flush`=1 and `stall`=1 together → bubble loaded and counter increments. Then assert `reset`=1 together with `flush`=1 → everything 0 and the counter cleared.
- Counter saturation: with `CNT_W`=4, issue 20 single-cycle flushes → `bubble_count` reaches 4'hF after 15 flushes and stays at 4'hF. Normal loads with `valid_id`=0 never change the counter.

Source files
------------

// File: rtl/id_ex_register_if.sv
// ID/EX stage bundle: ID-side fields flow into the pipeline register,
// EX-side fields are its registered copies.
interface id_ex_register_if;
   logic        valid_id;
   logic        reg_write_id;
   logic        mem_to_reg_id;
   logic        mem_read_id;
   logic        mem_write_id;
   logic        branch_id;
   logic        alu_src_id;
   logic        reg_dst_id;
   logic [1:0]  alu_op_id;
   logic [5:0]  funct_id;
   logic [31:0] pc_plus4_id;
   logic [31:0] rd1_id;
   logic [31:0] rd2_id;
   logic [31:0] imm_id;
   logic [4:0]  rs_id;
   logic [4:0]  rt_id;
   logic [4:0]  rd_id;

   logic        valid_ex;
   logic        reg_write_ex;
   logic        mem_to_reg_ex;
   logic        mem_read_ex;
   logic        mem_write_ex;
   logic        branch_ex;
   logic        alu_src_ex;
   logic        reg_dst_ex;
   logic [1:0]  alu_op_ex;
   logic [5:0]  funct_ex;
   logic [31:0] pc_plus4_ex;
   logic [31:0] rd1_ex;
   logic [31:0] rd2_ex;
   logic [31:0] imm_ex;
   logic [4:0]  rs_ex;
   logic [4:0]  rt_ex;
   logic [4:0]  rd_ex;

   // Driven by the decode stage, observes the EX-side copies.
   modport master (
      output valid_id, reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id,
             branch_id, alu_src_id, reg_dst_id, alu_op_id, funct_id,
             pc_plus4_id, rd1_id, rd2_id, imm_id, rs_id, rt_id, rd_id,
      input  valid_ex, reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
             branch_ex, alu_src_ex, reg_dst_ex, alu_op_ex, funct_ex,
             pc_plus4_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex
   );

   // The pipeline register itself.
   modport slave (
      input  valid_id, reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id,
             branch_id, alu_src_id, reg_dst_id, alu_op_id, funct_id,
             pc_plus4_id, rd1_id, rd2_id, imm_id, rs_id, rt_id, rd_id,
      output valid_ex, reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
             branch_ex, alu_src_ex, reg_dst_ex, alu_op_ex, funct_ex,
             pc_plus4_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex
   );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with hazard-unit stall/flush and a saturating
// count of inserted bubbles.
module id_ex_register #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   id_ex_register_if.slave  bus,
   output logic [CNT_W-1:0] bubble_count
);

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic [31:0] pc_plus4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } stage_t;

   stage_t           id_fields;
   stage_t           ex_q;
   logic [CNT_W-1:0] count_q;
   logic             count_full;

   assign id_fields = {bus.valid_id, bus.reg_write_id, bus.mem_to_reg_id,
                       bus.mem_read_id, bus.mem_write_id, bus.branch_id,
                       bus.alu_src_id, bus.reg_dst_id, bus.alu_op_id,
                       bus.funct_id, bus.pc_plus4_id, bus.rd1_id, bus.rd2_id,
                       bus.imm_id, bus.rs_id, bus.rt_id, bus.rd_id};

   assign count_full = (count_q == {CNT_W{1'b1}});

   // Control semantics: reset beats flush, flush beats stall, stall beats load.
   // A flushed slot is fully zeroed, so the bubble is an invalid add with no writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q    <= '0;
         count_q <= '0;
      end else if (flush) begin
         ex_q <= '0;
         if (!count_full) begin
            count_q <= count_q + 1'b1;
         end
      end else if (!stall) begin
         ex_q <= id_fields;
      end
   end

   assign bus.valid_ex      = ex_q.valid;
   assign bus.reg_write_ex  = ex_q.reg_write;
   assign bus.mem_to_reg_ex = ex_q.mem_to_reg;
   assign bus.mem_read_ex   = ex_q.mem_read;
   assign bus.mem_write_ex  = ex_q.mem_write;
   assign bus.branch_ex     = ex_q.branch;
   assign bus.alu_src_ex    = ex_q.alu_src;
   assign bus.reg_dst_ex    = ex_q.reg_dst;
   assign bus.alu_op_ex     = ex_q.alu_op;
   assign bus.funct_ex      = ex_q.funct;
   assign bus.pc_plus4_ex   = ex_q.pc_plus4;
   assign bus.rd1_ex        = ex_q.rd1;
   assign bus.rd2_ex        = ex_q.rd2;
   assign bus.imm_ex        = ex_q.imm;
   assign bus.rs_ex         = ex_q.rs;
   assign bus.rt_ex         = ex_q.rt;
   assign bus.rd_ex         = ex_q.rd;
   assign bubble_count      = count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: reset, transfer, stall, flush,
// flush/stall/reset priority and bubble-counter saturation (CNT_W = 4).
module tb_id_ex_register;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic [31:0] pc_plus4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } vec_t;

   logic             clk;
   logic             reset;
   logic             stall;
   logic             flush;
   logic [CNT_W-1:0] bubble_count;
   int               checks;
   int               failures;

   id_ex_register_if bus ();

   id_ex_register #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .bus          (bus),
      .bubble_count (bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_id(input vec_t v);
      bus.valid_id      = v.valid;
      bus.reg_write_id  = v.reg_write;
      bus.mem_to_reg_id = v.mem_to_reg;
      bus.mem_read_id   = v.mem_read;
      bus.mem_write_id  = v.mem_write;
      bus.branch_id     = v.branch;
      bus.alu_src_id    = v.alu_src;
      bus.reg_dst_id    = v.reg_dst;
      bus.alu_op_id     = v.alu_op;
      bus.funct_id      = v.funct;
      bus.pc_plus4_id   = v.pc_plus4;
      bus.rd1_id        = v.rd1;
      bus.rd2_id        = v.rd2;
      bus.imm_id        = v.imm;
      bus.rs_id         = v.rs;
      bus.rt_id         = v.rt;
      bus.rd_id         = v.rd;
   endtask

   function automatic vec_t sample_ex();
      return {bus.valid_ex, bus.reg_write_ex, bus.mem_to_reg_ex, bus.mem_read_ex,
              bus.mem_write_ex, bus.branch_ex, bus.alu_src_ex, bus.reg_dst_ex,
              bus.alu_op_ex, bus.funct_ex, bus.pc_plus4_ex, bus.rd1_ex,
              bus.rd2_ex, bus.imm_ex, bus.rs_ex, bus.rt_ex, bus.rd_ex};
   endfunction

   // Advance one rising edge and settle 1 ns past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t got;
      drive_id('1);
      reset = 1'b1;
      tick();
      tick();
      got = sample_ex();
      checks++;
      if (got !== '0) begin
         $display("FAIL reset_fields got=%h exp=0", got);
         failures++;
      end
      checks++;
      if (bubble_count !== 4'h0) begin
         $display("FAIL reset_count got=%h exp=0", bubble_count);
         failures++;
      end
      reset = 1'b0;
      tick();
      got = sample_ex();
      checks++;
      if (got !== '1) begin
         $display("FAIL reset_first_load got=%h exp=all-ones", got);
         failures++;
      end
   endtask

   task automatic test_transfer();
      vec_t v;
      vec_t got;
      vec_t seq[4];
      v = '0;
      v.valid     = 1'b1;
      v.alu_op    = 2'b10;
      v.funct     = 6'b100010;
      v.rd1       = 32'h0000_0005;
      v.rd2       = 32'h0000_0003;
      v.rd        = 5'd9;
      v.reg_write = 1'b1;
      drive_id(v);
      tick();
      got = sample_ex();
      checks++;
      if (got !== v) begin
         $display("FAIL transfer_sub got=%h exp=%h", got, v);
         failures++;
      end
      seq[0] = {1'b1, 7'b1000011, 2'b10, 6'b100000, 32'h0040_0004,
                32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 5'd1, 5'd2, 5'd3};
      seq[1] = {1'b1, 7'b1101010, 2'b00, 6'b000000, 32'h0040_0008,
                32'h1000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd29, 5'd8, 5'd0};
      seq[2] = {1'b1, 7'b0001110, 2'b00, 6'b101011, 32'h0040_000C,
                32'h1000_0040, 32'hCAFE_F00D, 32'h0000_0010, 5'd4, 5'd5, 5'd0};
      seq[3] = {1'b1, 7'b0000100, 2'b01, 6'b111111, 32'h0040_0010,
                32'h0000_0007, 32'h0000_0007, 32'h0000_0003, 5'd6, 5'd7, 5'd0};
      for (int i = 0; i < 4; i++) begin
         drive_id(seq[i]);
         tick();
         got = sample_ex();
         checks++;
         if (got !== seq[i]) begin
            $display("FAIL back_to_back_%0d got=%h exp=%h", i, got, seq[i]);
            failures++;
         end
      end
   endtask

   task automatic test_stall();
      vec_t a;
      vec_t c;
      vec_t got;
      a = '0;
      a.valid = 1'b1;
      a.reg_write = 1'b1;
      a.reg_dst = 1'b1;
      a.alu_op = 2'b10;
      a.funct = 6'b100100;
      a.rd1 = 32'h0F0F_00FF;
      a.rd2 = 32'h00FF_0F0F;
      a.rs = 5'd10;
      a.rt = 5'd11;
      a.rd = 5'd12;
      drive_id(a);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id({1'b1, 7'b1111111, 2'b11, 6'h15, 32'hA5A5_0000 + i,
                   32'h1234_5678, 32'h8765_4321, 32'hFFFF_0000, 5'd31, 5'd30, 5'd29});
         tick();
         got = sample_ex();
         checks++;
         if (got !== a) begin
            $display("FAIL stall_hold_%0d got=%h exp=%h", i, got, a);
            failures++;
         end
      end
      checks++;
      if (bubble_count !== 4'h0) begin
         $display("FAIL stall_count got=%h exp=0", bubble_count);
         failures++;
      end
      stall = 1'b0;
      c = {1'b1, 7'b0100010, 2'b00, 6'b000001, 32'h0040_0020,
           32'h0000_0100, 32'h0000_0200, 32'h0000_0040, 5'd13, 5'd14, 5'd15};
      drive_id(c);
      tick();
      got = sample_ex();
      checks++;
      if (got !== c) begin
         $display("FAIL stall_release got=%h exp=%h", got, c);
         failures++;
      end
   endtask

   task automatic test_flush();
      vec_t v;
      vec_t got;
      v = '0;
      v.valid = 1'b1;
      v.reg_write = 1'b1;
      v.mem_write = 1'b1;
      v.alu_op = 2'b11;
      v.rd1 = 32'h0000_00AA;
      drive_id(v);
      tick();
      got = sample_ex();
      checks++;
      if (got !== v) begin
         $display("FAIL flush_preload got=%h exp=%h", got, v);
         failures++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      got = sample_ex();
      checks++;
      if (got !== '0) begin
         $display("FAIL flush_bubble got=%h exp=0", got);
         failures++;
      end
      checks++;
      if (bubble_count !== 4'h1) begin
         $display("FAIL flush_count got=%h exp=1", bubble_count);
         failures++;
      end
   endtask

   task automatic test_flush_stall_reset();
      vec_t got;
      drive_id('1);
      flush = 1'b1;
      stall = 1'b1;
      tick();
      got = sample_ex();
      checks++;
      if (got !== '0) begin
         $display("FAIL flush_over_stall got=%h exp=0", got);
         failures++;
      end
      checks++;
      if (bubble_count !== 4'h2) begin
         $display("FAIL flush_over_stall_count got=%h exp=2", bubble_count);
         failures++;
      end
      stall = 1'b0;
      tick();
      checks++;
      if (bubble_count !== 4'h3) begin
         $display("FAIL flush_again_count got=%h exp=3", bubble_count);
         failures++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      flush = 1'b0;
      got = sample_ex();
      checks++;
      if (got !== '0) begin
         $display("FAIL reset_over_flush got=%h exp=0", got);
         failures++;
      end
      checks++;
      if (bubble_count !== 4'h0) begin
         $display("FAIL reset_over_flush_count got=%h exp=0", bubble_count);
         failures++;
      end
   endtask

   task automatic test_saturation();
      vec_t v;
      vec_t got;
      logic [CNT_W-1:0] exp_cnt;
      for (int i = 1; i <= 20; i++) begin
         drive_id('1);
         flush = 1'b1;
         tick();
         flush = 1'b0;
         exp_cnt = (i > 15) ? 4'hF : 4'(i);
         got = sample_ex();
         checks++;
         if (bubble_count !== exp_cnt || got !== '0) begin
            $display("FAIL sat_flush_%0d count=%h exp=%h fields=%h exp=0",
                     i, bubble_count, exp_cnt, got);
            failures++;
         end
         v = {1'b0, 7'b1010101, 2'b10, 6'(i), 32'h0040_1000 + 32'(i),
              32'(i) * 32'h0101_0101, 32'hFFFF_FFFF - 32'(i), 32'(i), 5'(i), 5'(i + 1), 5'(i + 2)};
         drive_id(v);
         tick();
         got = sample_ex();
         checks++;
         if (bubble_count !== exp_cnt || got !== v) begin
            $display("FAIL sat_invalid_load_%0d count=%h exp=%h fields=%h exp=%h",
                     i, bubble_count, exp_cnt, got, v);
            failures++;
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      drive_id('0);
      test_reset();
      test_transfer();
      test_stall();
      test_flush();
      test_flush_stall_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
